// File: rtl/uart_hex_word_assembler.sv
// Collects ASCII hex characters from the UART RX strobe into one right-aligned word,
// presents it on a terminator, and flags bad characters, overflow, drops and timeout.
module uart_hex_word_assembler #(
  parameter int          NDIG   = 4,
  parameter logic [7:0]  TERM   = 8'h0D,
  parameter int          TO_CYC = 50000,
  localparam int         WW     = 4 * NDIG,
  localparam int         CW     = $clog2(NDIG + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  output logic [WW-1:0] word,
  output logic          word_vld,
  input  logic          word_rdy,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          busy,
  output logic [CW-1:0] dig_cnt,
  output logic [2:0]    dbg_state
);

  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NDIG);
  localparam logic [1:0]    E_TIMEOUT = 2'd0;
  localparam logic [1:0]    E_BADCHR  = 2'd1;
  localparam logic [1:0]    E_OVFL    = 2'd2;
  localparam logic [1:0]    E_DROP    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACC     = 3'd1,
    S_FULL    = 3'd2,
    S_DISCARD = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t        state_q;
  logic [WW-1:0] word_q;
  logic          word_vld_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [CW-1:0] dig_cnt_q;
  logic [TW-1:0] to_cnt_q;

  logic          is_hex;
  logic          is_term;
  logic [3:0]    hex_val;
  logic [WW-1:0] word_shift;
  logic [CW-1:0] cnt_inc;
  logic          to_hit;

  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      hex_val = rx_data[3:0];
    else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66))
      hex_val = rx_data[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  assign is_term    = (rx_data == TERM);
  assign word_shift = (word_q << 4) | WW'(hex_val);
  assign cnt_inc    = dig_cnt_q + CW'(1);
  assign to_hit     = (TO_CYC != 0) && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= E_TIMEOUT;
      dig_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // An empty line (bare terminator) is silently ignored here.
          if (rx_vld && !is_term) begin
            to_cnt_q <= '0;
            if (is_hex) begin
              word_q    <= word_shift;
              dig_cnt_q <= cnt_inc;
              state_q   <= (cnt_inc == CNT_MAX) ? S_FULL : S_ACC;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= E_BADCHR;
              state_q    <= S_DISCARD;
            end
          end
        end
        S_ACC, S_FULL, S_DISCARD: begin
          if (rx_vld) begin
            to_cnt_q <= '0;
            if (is_term) begin
              if (state_q == S_DISCARD) begin
                word_q    <= '0;
                dig_cnt_q <= '0;
                state_q   <= S_IDLE;
              end else begin
                word_vld_q <= 1'b1;
                state_q    <= S_HOLD;
              end
            end else if (state_q != S_DISCARD) begin
              if (is_hex && state_q == S_ACC) begin
                word_q    <= word_shift;
                dig_cnt_q <= cnt_inc;
                if (cnt_inc == CNT_MAX) state_q <= S_FULL;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= is_hex ? E_OVFL : E_BADCHR;
                state_q    <= S_DISCARD;
              end
            end
          end else if (to_hit) begin
            err_q      <= 1'b1;
            err_code_q <= E_TIMEOUT;
            word_q     <= '0;
            dig_cnt_q  <= '0;
            to_cnt_q   <= '0;
            state_q    <= S_IDLE;
          end else if (TO_CYC != 0) begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_HOLD: begin
          // Bytes arriving while the word waits are lost, even on the accept cycle.
          if (rx_vld) begin
            err_q      <= 1'b1;
            err_code_q <= E_DROP;
          end
          if (word_rdy) begin
            word_q     <= '0;
            dig_cnt_q  <= '0;
            word_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign word      = word_q;
  assign word_vld  = word_vld_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign dig_cnt   = dig_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_hex_word_assembler.sv
// Bench for uart_hex_word_assembler: vector table, multi-cycle corner sequences and
// random byte streams checked against a line-level behavioural model.
module tb_uart_hex_word_assembler;

  localparam int NDIG   = 4;
  localparam int TO_CYC = 24;
  localparam logic [7:0] CR = 8'h0D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic [15:0] word;
  logic        word_vld;
  logic        word_rdy = 1'b0;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic [2:0]  dig_cnt;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  uart_hex_word_assembler #(.NDIG(NDIG), .TERM(CR), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .word(word), .word_vld(word_vld), .word_rdy(word_rdy), .err(err),
    .err_code(err_code), .busy(busy), .dig_cnt(dig_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: the current line as a list of digit values plus two modes.
  int         m_digs[$];
  bit         m_disc;
  bit         m_hold;
  int         m_idle;
  bit         m_err;
  logic [1:0] m_code;

  function automatic int hex_of(input logic [7:0] c);
    string      digits = "0123456789abcdef";
    logic [7:0] lc = c;
    if (c >= 8'h41 && c <= 8'h5A) lc = c + 8'h20;
    for (int i = 0; i < 16; i++) if (digits[i] == lc) return i;
    return -1;
  endfunction

  function automatic logic [15:0] m_word();
    int w = 0;
    foreach (m_digs[i]) w = w * 16 + m_digs[i];
    return w[15:0];
  endfunction

  task automatic model_reset();
    m_digs.delete();
    m_disc = 0; m_hold = 0; m_idle = 0; m_err = 0; m_code = 2'd0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
    m_err = 0;
    if (m_hold) begin
      if (v) begin m_err = 1; m_code = 2'd3; end
      if (r) begin m_hold = 0; m_digs.delete(); end
    end else if (v) begin
      m_idle = 0;
      if (m_disc) begin
        if (d == CR) begin m_disc = 0; m_digs.delete(); end
      end else if (d == CR) begin
        if (m_digs.size() > 0) m_hold = 1;
      end else if (hex_of(d) >= 0) begin
        if (m_digs.size() == NDIG) begin m_err = 1; m_code = 2'd2; m_disc = 1; end
        else m_digs.push_back(hex_of(d));
      end else begin
        m_err = 1; m_code = 2'd1; m_disc = 1;
      end
    end else if (m_disc || m_digs.size() > 0) begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        m_err = 1; m_code = 2'd0; m_disc = 0; m_idle = 0; m_digs.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    rx_vld = v; rx_data = d; word_rdy = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    rx_vld = 1'b0; word_rdy = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".word"},     32'(word),     32'(m_word()));
    chk({tag, ".word_vld"}, 32'(word_vld), 32'(m_hold));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, ".busy"},     32'(busy),     32'(m_hold || m_disc || m_digs.size() > 0));
    chk({tag, ".dig_cnt"},  32'(dig_cnt),  32'(m_digs.size()));
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          r;
    logic [15:0] w;
    bit          wv;
    bit          e;
    logic [1:0]  c;
    bit          b;
    logic [2:0]  n;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [7:0] d, input bit r, input logic [15:0] w,
                              input bit wv, input bit e, input logic [1:0] c, input bit b,
                              input logic [2:0] n);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.w = w; x.wv = wv; x.e = e; x.c = c; x.b = b; x.n = n;
    return x;
  endfunction

  task automatic chk_outs(input string tag, input logic [15:0] w, input bit wv, input bit e,
                          input logic [1:0] c, input bit b, input logic [2:0] n);
    chk({tag, ".word"},     32'(word),     32'(w));
    chk({tag, ".word_vld"}, 32'(word_vld), 32'(wv));
    chk({tag, ".err"},      32'(err),      32'(e));
    chk({tag, ".err_code"}, 32'(err_code), 32'(c));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".dig_cnt"},  32'(dig_cnt),  32'(n));
  endtask

  vec_t tbl[$];

  initial begin
    string      hexs = "0123456789abcdefABCDEF";
    logic [7:0] junk[6] = '{8'h47, 8'h7A, 8'h20, 8'h0A, 8'h00, 8'hFF};

    // Line "1a3" CR, accept
    tbl.push_back(mk(1, "1", 0, 16'h0001, 0, 0, 2'd0, 1, 3'd1));
    tbl.push_back(mk(1, "a", 0, 16'h001A, 0, 0, 2'd0, 1, 3'd2));
    tbl.push_back(mk(1, "3", 0, 16'h01A3, 0, 0, 2'd0, 1, 3'd3));
    tbl.push_back(mk(1, CR,  0, 16'h01A3, 1, 0, 2'd0, 1, 3'd3));
    tbl.push_back(mk(0, 0,   1, 16'h0000, 0, 0, 2'd0, 0, 3'd0));
    // Five digits overflow
    tbl.push_back(mk(1, "1", 0, 16'h0001, 0, 0, 2'd0, 1, 3'd1));
    tbl.push_back(mk(1, "2", 0, 16'h0012, 0, 0, 2'd0, 1, 3'd2));
    tbl.push_back(mk(1, "3", 0, 16'h0123, 0, 0, 2'd0, 1, 3'd3));
    tbl.push_back(mk(1, "4", 0, 16'h1234, 0, 0, 2'd0, 1, 3'd4));
    tbl.push_back(mk(1, "5", 0, 16'h1234, 0, 1, 2'd2, 1, 3'd4));
    tbl.push_back(mk(1, CR,  0, 16'h0000, 0, 0, 2'd2, 0, 3'd0));
    // Bad character, later digit dropped silently
    tbl.push_back(mk(1, "1", 0, 16'h0001, 0, 0, 2'd2, 1, 3'd1));
    tbl.push_back(mk(1, "G", 0, 16'h0001, 0, 1, 2'd1, 1, 3'd1));
    tbl.push_back(mk(1, "7", 0, 16'h0001, 0, 0, 2'd1, 1, 3'd1));
    tbl.push_back(mk(1, CR,  0, 16'h0000, 0, 0, 2'd1, 0, 3'd0));
    // Empty line, bad char from idle
    tbl.push_back(mk(1, CR,  0, 16'h0000, 0, 0, 2'd1, 0, 3'd0));
    tbl.push_back(mk(1, "x", 0, 16'h0000, 0, 1, 2'd1, 1, 3'd0));
    tbl.push_back(mk(1, CR,  0, 16'h0000, 0, 0, 2'd1, 0, 3'd0));
    // Mixed case, full word then terminator
    tbl.push_back(mk(1, "f", 0, 16'h000F, 0, 0, 2'd1, 1, 3'd1));
    tbl.push_back(mk(1, "A", 0, 16'h00FA, 0, 0, 2'd1, 1, 3'd2));
    tbl.push_back(mk(1, "0", 0, 16'h0FA0, 0, 0, 2'd1, 1, 3'd3));
    tbl.push_back(mk(1, "9", 0, 16'hFA09, 0, 0, 2'd1, 1, 3'd4));
    tbl.push_back(mk(1, CR,  0, 16'hFA09, 1, 0, 2'd1, 1, 3'd4));
    tbl.push_back(mk(0, 0,   1, 16'h0000, 0, 0, 2'd1, 0, 3'd0));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 16'h0, 0, 0, 2'd0, 0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk_outs($sformatf("vec%0d", i), tbl[i].w, tbl[i].wv, tbl[i].e, tbl[i].c, tbl[i].b, tbl[i].n);
    end

    // Timeout exactly TO_CYC idle cycles after the last byte
    step(1, "F", 0);
    repeat (TO_CYC - 1) step(0, 0, 0);
    chk_outs("to_before", 16'h000F, 0, 0, 2'd1, 1, 3'd1);
    step(0, 0, 0);
    chk_outs("to_hit", 16'h0000, 0, 1, 2'd0, 0, 3'd0);
    step(0, 0, 0);
    chk_outs("to_after", 16'h0000, 0, 0, 2'd0, 0, 3'd0);

    // Held word, dropped bytes, drop on the accept cycle
    step(1, "F", 0); step(1, "F", 0); step(1, CR, 0);
    chk_outs("hold", 16'h00FF, 1, 0, 2'd0, 1, 3'd2);
    step(1, "3", 0);
    chk_outs("hold_drop", 16'h00FF, 1, 1, 2'd3, 1, 3'd2);
    repeat (3) step(0, 0, 0);
    chk_outs("hold_wait", 16'h00FF, 1, 0, 2'd3, 1, 3'd2);
    step(1, "4", 1);
    chk_outs("hold_acc_drop", 16'h0000, 0, 1, 2'd3, 0, 3'd0);
    step(0, 0, 0);
    chk_outs("hold_done", 16'h0000, 0, 0, 2'd3, 0, 3'd0);

    // Asynchronous reset mid-word
    step(1, "A", 0); step(1, "B", 0);
    chk_outs("pre_rst", 16'h00AB, 0, 0, 2'd3, 1, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 16'h0000, 0, 0, 2'd0, 0, 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(1, "5", 0); step(1, CR, 0);
    chk_outs("post_rst", 16'h0005, 1, 0, 2'd0, 1, 3'd1);
    step(0, 0, 1);
    chk_outs("post_rst_acc", 16'h0000, 0, 0, 2'd0, 0, 3'd0);

    // Random byte streams against the model
    for (int k = 0; k < 500; k++) begin
      int  kind = $urandom_range(0, 9);
      bit  r    = ($urandom_range(0, 2) == 0);
      if (kind <= 5) begin
        step(1, hexs[$urandom_range(0, 21)], r);
        chk_model("rnd_hex");
      end else if (kind == 6) begin
        step(1, CR, r);
        chk_model("rnd_term");
      end else if (kind == 7) begin
        step(1, junk[$urandom_range(0, 5)], r);
        chk_model("rnd_bad");
      end else begin
        int gap = ($urandom_range(0, 4) == 0) ? $urandom_range(TO_CYC - 2, TO_CYC + 3)
                                              : $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          step(0, 8'h00, ($urandom_range(0, 3) == 0));
          chk_model("rnd_gap");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
